// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM stage, the load/store access unit and the word-organised data memory.
// The unit takes the slave modport; the pipeline/memory side takes the master modport.
interface mem_access_unit_if #(
    parameter int ADDR_HI = 11
);
    logic                 req_valid;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 stall;
    logic                 done;
    logic [31:0]          rdata;
    logic                 dm_we;
    logic [ADDR_HI-2:0]   dm_addr;
    logic [3:0]           dm_be;
    logic [31:0]          dm_din;
    logic [31:0]          dm_dout;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        input  stall, done, rdata, dm_we, dm_addr, dm_be, dm_din
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        output stall, done, rdata, dm_we, dm_addr, dm_be, dm_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: splits byte/half/word accesses of any alignment into
// memory beats with supported byte enables, assembles and extends load results.
module mem_access_unit #(
    parameter int ADDR_HI = 11
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave mau
);
    localparam int WW = ADDR_HI - 1;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

    typedef struct packed {
        logic [3:0] be;
        logic       inc;   // beat targets word w+1
        logic [1:0] src;   // first data byte carried by this beat
    } beat_t;

    function automatic logic [1:0] beat_count(logic [1:0] size, logic [1:0] off);
        logic [1:0] n;
        n = 2'd1;
        if (size == 2'b01)
            n = off[0] ? 2'd2 : 2'd1;
        else if (size != 2'b00)
            n = (off == 2'd0) ? 2'd1 : (off == 2'd2) ? 2'd2 : 2'd3;
        return n;
    endfunction

    function automatic beat_t beat_of(logic [1:0] size, logic [1:0] off, logic [1:0] k);
        beat_t b;
        b = '{be: 4'b0001, inc: 1'b0, src: 2'd0};
        if (size == 2'b00) begin
            b.be = 4'b0001 << off;
        end else if (size == 2'b01) begin
            case (off)
                2'd0: b.be = 4'b0011;
                2'd2: b.be = 4'b1100;
                2'd1: if (k == 2'd0) b.be = 4'b0010;
                      else begin b.be = 4'b0100; b.src = 2'd1; end
                default: if (k == 2'd0) b.be = 4'b1000;
                         else begin b.be = 4'b0001; b.inc = 1'b1; b.src = 2'd1; end
            endcase
        end else begin
            case (off)
                2'd0: b.be = 4'b1111;
                2'd2: if (k == 2'd0) b.be = 4'b1100;
                      else begin b.be = 4'b0011; b.inc = 1'b1; b.src = 2'd2; end
                2'd1: case (k)
                          2'd0:    b.be = 4'b0010;
                          2'd1:    begin b.be = 4'b1100; b.src = 2'd1; end
                          default: begin b.be = 4'b0001; b.inc = 1'b1; b.src = 2'd3; end
                      endcase
                default: case (k)
                          2'd0:    b.be = 4'b1000;
                          2'd1:    begin b.be = 4'b0011; b.inc = 1'b1; b.src = 2'd1; end
                          default: begin b.be = 4'b0100; b.inc = 1'b1; b.src = 2'd3; end
                      endcase
            endcase
        end
        return b;
    endfunction

    function automatic logic [31:0] extend(logic [1:0] size, logic uns, logic [31:0] a);
        case (size)
            2'b00:   return {{24{a[7] & ~uns}}, a[7:0]};
            2'b01:   return {{16{a[15] & ~uns}}, a[15:0]};
            default: return a;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [1:0]     n_q, n_d;
    logic           write_q, write_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [ADDR_HI:0] addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    asm_q, asm_d;
    logic [31:0]    rdata_q, rdata_d;

    beat_t          beat;
    logic [2:0]     cnt;
    logic [1:0]     lane0;
    logic [1:0]     pos;
    logic [31:0]    wsh;
    logic [31:0]    dsh;

    always_comb begin
        beat  = beat_of(size_q, addr_q[1:0], k_q);
        cnt   = (beat.be == 4'b1111) ? 3'd4 :
                (beat.be == 4'b0011 || beat.be == 4'b1100) ? 3'd2 : 3'd1;
        lane0 = beat.be[0] ? 2'd0 : beat.be[1] ? 2'd1 : beat.be[2] ? 2'd2 : 2'd3;
        wsh   = wdata_q >> {beat.src, 3'b000};
        dsh   = mau.dm_dout >> {lane0, 3'b000};
    end

    // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        pos         = 2'd0;
        mau.stall   = 1'b0;
        mau.done    = 1'b0;
        mau.dm_we   = 1'b0;
        mau.dm_be   = 4'b0000;
        mau.dm_addr = '0;
        mau.dm_din  = '0;

        case (state_q)
            IDLE: begin
                mau.stall = mau.req_valid & ~rst;
                if (mau.req_valid) begin
                    write_d = mau.req_write;
                    size_d  = mau.req_size;
                    uns_d   = mau.req_unsigned;
                    addr_d  = mau.req_addr[ADDR_HI:0];
                    wdata_d = mau.req_wdata;
                    k_d     = 2'd0;
                    n_d     = beat_count(mau.req_size, mau.req_addr[1:0]);
                    asm_d   = '0;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                mau.stall   = 1'b1;
                mau.dm_we   = write_q;
                mau.dm_be   = beat.be;
                mau.dm_addr = addr_q[ADDR_HI:2] + WW'(beat.inc);
                mau.dm_din  = (cnt == 3'd4) ? wsh :
                              (cnt == 3'd2) ? {16'h0, wsh[15:0]} : {24'h0, wsh[7:0]};
                if (!write_q) begin
                    // Enabled lanes land contiguously in the result starting at byte src.
                    for (int j = 0; j < 4; j++) begin
                        if (3'(j) < cnt) begin
                            pos = beat.src + 2'(j);
                            asm_d[{pos, 3'b000} +: 8] = dsh[8*j +: 8];
                        end
                    end
                end
                if (k_q == n_q - 2'd1) begin
                    state_d = RESP;
                    if (!write_q) rdata_d = extend(size_q, uns_q, asm_d);
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            RESP: begin
                mau.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mau.rdata = rdata_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            n_q     <= 2'd0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected beats and
// responses; a negedge monitor pops and compares whatever the unit presents.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_HI(11)) bus();
    mem_access_unit #(.ADDR_HI(11)) dut (.clk(clk), .rst(rst), .mau(bus));

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
    } beat_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } resp_exp_t;

    logic [31:0] mem [0:1023];
    beat_exp_t   beat_q[$];
    resp_exp_t   resp_q[$];
    int          cyc = 0;
    int          issue_cyc = 0;
    int          checks = 0;
    int          failures = 0;

    assign bus.dm_dout = mem[bus.dm_addr];

    // Memory takes write data from the low bytes, filling enabled lanes in ascending order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dm_we) begin
            automatic logic [31:0] w = mem[bus.dm_addr];
            automatic int b = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.dm_be[i]) begin
                    w[8*i +: 8] = bus.dm_din[8*b +: 8];
                    b++;
                end
            end
            mem[bus.dm_addr] <= w;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dm_we || bus.dm_be != 4'b0000) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat_be", {28'h0, bus.dm_be}, 32'h0);
                end else begin
                    automatic beat_exp_t e = beat_q.pop_front();
                    check("beat_we",   {31'h0, bus.dm_we},   {31'h0, e.we});
                    check("beat_addr", {22'h0, bus.dm_addr}, {22'h0, e.addr});
                    check("beat_be",   {28'h0, bus.dm_be},   {28'h0, e.be});
                    check("beat_din",  bus.dm_din,           e.din);
                end
            end
            if (bus.done) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    automatic resp_exp_t r = resp_q.pop_front();
                    check("resp_rdata",   bus.rdata, r.rdata);
                    check("resp_latency", cyc - issue_cyc, r.lat);
                    check("resp_stall",   {31'h0, bus.stall}, 32'h0);
                end
            end
        end
    end

    task automatic exp_beat(input logic we, input logic [9:0] a, input logic [3:0] be,
                            input logic [31:0] din);
        beat_q.push_back('{we: we, addr: a, be: be, din: din});
    endtask

    task automatic drive_req(input logic w, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        issue_cyc        = cyc;
    endtask

    task automatic op(input logic w, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input int lat);
        bit seen = 1'b0;
        @(negedge clk);
        resp_q.push_back('{rdata: exp_rdata, lat: lat});
        drive_req(w, size, uns, addr, wdata);
        #1 check("stall_accept", {31'h0, bus.stall}, 32'h1);
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else check("stall_busy", {31'h0, bus.stall}, 32'h1);
        end
        if (!seen) check("done_timeout", 32'h0, 32'h1);
        bus.req_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"}, {31'h0, bus.stall}, 32'h0);
        check({tag, "_done"},  {31'h0, bus.done},  32'h0);
        check({tag, "_rdata"}, bus.rdata, 32'h0);
        check({tag, "_we"},    {31'h0, bus.dm_we}, 32'h0);
        check({tag, "_be"},    {28'h0, bus.dm_be}, 32'h0);
        check({tag, "_addr"},  {22'h0, bus.dm_addr}, 32'h0);
        check({tag, "_din"},   bus.dm_din, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]  = 32'h80FF7F01;
        mem[12] = 32'h44332211;
        mem[13] = 32'h88776655;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst = 1'b1;
        #1 check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Aligned word store and load back.
        exp_beat(1'b1, 10'd4, 4'b1111, 32'hDEADBEEF);
        op(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 2);
        exp_beat(1'b0, 10'd4, 4'b1111, 32'h0);
        op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 2);

        // Half store straddling words 1/2; upper wdata bits must not leak.
        exp_beat(1'b1, 10'd1, 4'b1000, 32'h34);
        exp_beat(1'b1, 10'd2, 4'b0001, 32'h12);
        op(1'b1, 2'b01, 1'b0, 32'h007, 32'hFFFF1234, 32'hDEADBEEF, 3);
        exp_beat(1'b0, 10'd1, 4'b1111, 32'h0);
        op(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 32'h34000000, 2);
        exp_beat(1'b0, 10'd1, 4'b1000, 32'h0);
        exp_beat(1'b0, 10'd2, 4'b0001, 32'h0);
        op(1'b0, 2'b01, 1'b1, 32'h007, 32'h0, 32'h00001234, 3);

        // Extension cases on word 5 = 0x80FF7F01.
        exp_beat(1'b0, 10'd5, 4'b0100, 32'h0);
        op(1'b0, 2'b00, 1'b0, 32'h016, 32'h0, 32'hFFFFFFFF, 2);
        exp_beat(1'b0, 10'd5, 4'b0100, 32'h0);
        op(1'b0, 2'b00, 1'b1, 32'h016, 32'h0, 32'h000000FF, 2);
        exp_beat(1'b0, 10'd5, 4'b0010, 32'h0);
        op(1'b0, 2'b00, 1'b0, 32'h015, 32'h0, 32'h0000007F, 2);
        exp_beat(1'b0, 10'd5, 4'b1100, 32'h0);
        op(1'b0, 2'b01, 1'b0, 32'h016, 32'h0, 32'hFFFF80FF, 2);
        exp_beat(1'b0, 10'd5, 4'b0010, 32'h0);
        exp_beat(1'b0, 10'd5, 4'b0100, 32'h0);
        op(1'b0, 2'b01, 1'b0, 32'h015, 32'h0, 32'hFFFFFF7F, 3);

        // Three-beat word load at offset 3.
        exp_beat(1'b0, 10'd12, 4'b1000, 32'h0);
        exp_beat(1'b0, 10'd13, 4'b0011, 32'h0);
        exp_beat(1'b0, 10'd13, 4'b0100, 32'h0);
        op(1'b0, 2'b10, 1'b0, 32'h033, 32'h0, 32'h77665544, 4);

        // Word store wrapping from word 1023 to word 0, then read back.
        exp_beat(1'b1, 10'd1023, 4'b1100, 32'h0000F00D);
        exp_beat(1'b1, 10'd0,    4'b0011, 32'h0000CAFE);
        op(1'b1, 2'b10, 1'b0, 32'hFFE, 32'hCAFEF00D, 32'h77665544, 3);
        exp_beat(1'b0, 10'd1023, 4'b1100, 32'h0);
        exp_beat(1'b0, 10'd0,    4'b0011, 32'h0);
        op(1'b0, 2'b10, 1'b0, 32'hFFE, 32'h0, 32'hCAFEF00D, 3);

        // Byte store into lane 3, then size 11 read treated as word.
        exp_beat(1'b1, 10'd2, 4'b1000, 32'hAB);
        op(1'b1, 2'b00, 1'b0, 32'h00B, 32'h123456AB, 32'hCAFEF00D, 2);
        exp_beat(1'b0, 10'd2, 4'b1111, 32'h0);
        op(1'b0, 2'b11, 1'b0, 32'h008, 32'h0, 32'hAB000012, 2);

        // Reset during beat 2 of a 3-beat store: beat 1 stays in memory.
        exp_beat(1'b1, 10'd8, 4'b0010, 32'hD4);
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h021, 32'hA1B2C3D4);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midop_reset");
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("beats_before_reset", beat_q.size(), 0);
        exp_beat(1'b0, 10'd8, 4'b1111, 32'h0);
        op(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0000D400, 2);

        repeat (3) @(negedge clk);
        check("beat_queue_drained", beat_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
